// File: rtl/flash_pkg.sv
// Shared encodings for the NOR-flash command engine: op codes, FSM states,
// AMD unlock constants and the per-op write sequence table.
package flash_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_PROG   = 2'd1,
    OP_SERASE = 2'd2,
    OP_CERASE = 2'd3
  } flash_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEQ,
    ST_WAIT,
    ST_ABORT,
    ST_RCYC,
    ST_DONE
  } flash_st_e;

  localparam logic [11:0] UNLOCK_A1 = 12'h555;
  localparam logic [11:0] UNLOCK_A2 = 12'h2AA;
  localparam logic [7:0]  D_AA = 8'hAA;
  localparam logic [7:0]  D_55 = 8'h55;
  localparam logic [7:0]  D_80 = 8'h80;
  localparam logic [7:0]  D_A0 = 8'hA0;
  localparam logic [7:0]  D_30 = 8'h30;
  localparam logic [7:0]  D_10 = 8'h10;
  localparam logic [7:0]  D_F0 = 8'hF0;

  localparam int PROG_LEN  = 4;
  localparam int ERASE_LEN = 6;

  // use_addr/use_wdata select the latched command fields instead of the constants
  typedef struct packed {
    logic        use_addr;
    logic [11:0] ua;
    logic        use_wdata;
    logic [7:0]  ud;
  } seq_ent_t;

  function automatic seq_ent_t seq_entry(input flash_op_e op, input logic [2:0] idx);
    seq_ent_t e;
    e = '{use_addr: 1'b0, ua: UNLOCK_A1, use_wdata: 1'b0, ud: D_AA};
    case (idx)
      3'd1, 3'd4: begin
        e.ua = UNLOCK_A2;
        e.ud = D_55;
      end
      3'd2: e.ud = (op == OP_PROG) ? D_A0 : D_80;
      3'd3: if (op == OP_PROG) begin
        e.use_addr  = 1'b1;
        e.use_wdata = 1'b1;
      end
      3'd5: if (op == OP_SERASE) begin
        e.use_addr = 1'b1;
        e.ud       = D_30;
      end else begin
        e.ud = D_10;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] seq_last(input flash_op_e op);
    return (op == OP_PROG) ? 3'(PROG_LEN - 1) : 3'(ERASE_LEN - 1);
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One flash bus cycle (read or write) of CYC_LEN clocks: phase counter,
// strobe decode, address/data hold and read-data capture.
module flash_bus_cycle #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int CYC_LEN = 4
) (
  input  logic              CLK50M,
  input  logic              RST,
  input  logic              start,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_dq_o,
  input  logic [DATA_W-1:0] flash_dq_i,
  output logic              flash_dq_oe,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n
);

  localparam int PH_W = $clog2(CYC_LEN);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYC_LEN - 1);
  localparam logic [PH_W-1:0] PH_SAMP = PH_W'(CYC_LEN - 2);

  logic            active;
  logic            wr;
  logic [PH_W-1:0] phase;

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      active     <= 1'b0;
      wr         <= 1'b0;
      phase      <= '0;
      flash_addr <= '0;
      flash_dq_o <= '0;
      rdata      <= '0;
    end else begin
      if (start) begin
        active     <= 1'b1;
        wr         <= is_write;
        phase      <= '0;
        flash_addr <= addr;
        if (is_write) flash_dq_o <= wdata;
      end else if (active) begin
        if (phase == PH_LAST) active <= 1'b0;
        else                  phase  <= phase + 1'b1;
      end
      // sample one clock before OE# rises so the device is still driving
      if (active && !wr && phase == PH_SAMP) rdata <= flash_dq_i;
    end
  end

  assign done        = active && (phase == PH_LAST);
  assign flash_dq_oe = active && wr;
  assign flash_ce_n  = !(active && (wr || phase != PH_LAST));
  assign flash_oe_n  = !(active && !wr && phase != PH_LAST);
  assign flash_we_n  = !(active && wr && phase != '0 && phase != PH_LAST);

endmodule

// File: rtl/flash_cmd_engine.sv
// NOR-flash command engine: turns one accepted command into a full AMD unlock
// sequence, waits for completion, recovers on timeout. FLASH_DATA_POLL_EN selects DQ7 polling.
module flash_cmd_engine
  import flash_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int CYC_LEN   = 4,
  parameter int TIMEOUT_W = 24
) (
  input  logic              CLK50M,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_dq_o,
  input  logic [DATA_W-1:0] flash_dq_i,
  output logic              flash_dq_oe,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  input  logic              flash_ready
);

  flash_st_e            st, st_nxt;
  flash_op_e            op_q;
  logic [2:0]           idx, idx_nxt;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;
  logic                 tmo_clr, err_set, rd_cap;

  logic              bc_start, bc_wr, bc_done;
  logic [ADDR_W-1:0] bc_addr;
  logic [DATA_W-1:0] bc_wdata, bc_rdata;

  seq_ent_t ent0, entn;
  assign ent0 = seq_entry(flash_op_e'(cmd_op), 3'd0);
  assign entn = seq_entry(op_q, idx + 3'd1);

`ifdef FLASH_DATA_POLL_EN
  logic poll_bit;
  assign poll_bit = (op_q == OP_PROG) ? wdata_q[7] : 1'b1;
`endif

  always_comb begin
    st_nxt   = st;
    idx_nxt  = idx;
    bc_start = 1'b0;
    bc_wr    = 1'b1;
    bc_addr  = addr_q;
    bc_wdata = wdata_q;
    tmo_clr  = 1'b0;
    err_set  = 1'b0;
    rd_cap   = 1'b0;
    case (st)
      ST_IDLE: if (cmd_valid) begin
        bc_start = 1'b1;
        idx_nxt  = 3'd0;
        if (flash_op_e'(cmd_op) == OP_READ) begin
          bc_wr   = 1'b0;
          bc_addr = cmd_addr;
          st_nxt  = ST_RCYC;
        end else begin
          bc_addr  = ent0.use_addr  ? cmd_addr  : ADDR_W'(ent0.ua);
          bc_wdata = ent0.use_wdata ? cmd_wdata : DATA_W'(ent0.ud);
          st_nxt   = ST_SEQ;
        end
      end
      ST_SEQ: if (bc_done) begin
        if (idx == seq_last(op_q)) begin
          st_nxt  = ST_WAIT;
          tmo_clr = 1'b1;
`ifdef FLASH_DATA_POLL_EN
          bc_start = 1'b1;
          bc_wr    = 1'b0;
`endif
        end else begin
          idx_nxt  = idx + 3'd1;
          bc_start = 1'b1;
          bc_addr  = entn.use_addr  ? addr_q  : ADDR_W'(entn.ua);
          bc_wdata = entn.use_wdata ? wdata_q : DATA_W'(entn.ud);
        end
      end
      ST_WAIT: begin
`ifdef FLASH_DATA_POLL_EN
        if (bc_done && bc_rdata[7] == poll_bit) begin
          st_nxt = ST_DONE;
        end else if (tmo_cnt == '1) begin
          st_nxt   = ST_ABORT;
          bc_start = 1'b1;
          bc_wdata = DATA_W'(D_F0);
        end else if (bc_done) begin
          bc_start = 1'b1;
          bc_wr    = 1'b0;
        end
`else
        // RY/BY# is not valid until tBUSY after the last write, hence the blanking window
        if (tmo_cnt >= TIMEOUT_W'(CYC_LEN) && flash_ready) begin
          st_nxt = ST_DONE;
        end else if (tmo_cnt == '1) begin
          st_nxt   = ST_ABORT;
          bc_start = 1'b1;
          bc_wdata = DATA_W'(D_F0);
        end
`endif
      end
      ST_ABORT: if (bc_done) begin
        st_nxt  = ST_DONE;
        err_set = 1'b1;
      end
      ST_RCYC: if (bc_done) begin
        st_nxt = ST_DONE;
        rd_cap = 1'b1;
      end
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      st      <= ST_IDLE;
      idx     <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_cnt <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      st  <= st_nxt;
      idx <= idx_nxt;
      if (st == ST_IDLE && cmd_valid) begin
        op_q    <= flash_op_e'(cmd_op);
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        err_q   <= 1'b0;
      end
      if (tmo_clr)             tmo_cnt <= '0;
      else if (st == ST_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
      if (err_set) err_q   <= 1'b1;
      if (rd_cap)  rdata_q <= bc_rdata;
    end
  end

  assign cmd_ready = (st == ST_IDLE);
  assign busy      = (st != ST_IDLE);
  assign rsp_valid = (st == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  flash_bus_cycle #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CYC_LEN(CYC_LEN)
  ) u_bus (
    .CLK50M     (CLK50M),
    .RST        (RST),
    .start      (bc_start),
    .is_write   (bc_wr),
    .addr       (bc_addr),
    .wdata      (bc_wdata),
    .done       (bc_done),
    .rdata      (bc_rdata),
    .flash_addr (flash_addr),
    .flash_dq_o (flash_dq_o),
    .flash_dq_i (flash_dq_i),
    .flash_dq_oe(flash_dq_oe),
    .flash_ce_n (flash_ce_n),
    .flash_oe_n (flash_oe_n),
    .flash_we_n (flash_we_n)
  );

endmodule

// File: tb/tb_flash_cmd_engine.sv
// Bench for flash_cmd_engine: each command is expanded into an expected per-cycle
// pin trace (bus cycles, wait, response) and compared every clock.
module tb_flash_cmd_engine;
  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int C   = 4;
  localparam int TW  = 6;
  localparam int TMO = (1 << TW) - 1;

  logic CLK50M = 1'b0;
  logic RST = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata, flash_dq_o, flash_dq_i;
  logic [AW-1:0] flash_addr;
  logic flash_dq_oe, flash_ce_n, flash_oe_n, flash_we_n, flash_ready;

  int cyc = 0;
  int rdy_cyc = 1 << 30;
  int total = 0, bad = 0;
  int acc_cyc, rv_cyc, n_oe, n_we;
  logic [DW-1:0] rv_data;
  logic rv_err;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic rdy, bsy, rv, err, ce, oe, we, doe;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
  } obs_t;
  typedef struct packed { obs_t v; obs_t m; } ent_t;
  ent_t exp_q[$];

  flash_cmd_engine #(.ADDR_W(AW), .DATA_W(DW), .CYC_LEN(C), .TIMEOUT_W(TW)) dut (
    .CLK50M(CLK50M), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_i(flash_dq_i),
    .flash_dq_oe(flash_dq_oe), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_ready(flash_ready)
  );

  always #10 CLK50M = ~CLK50M;
  always @(posedge CLK50M) cyc <= cyc + 1;

  // flash array contents and RY/BY# behaviour
  function automatic logic [DW-1:0] dq_fn(input logic [AW-1:0] a);
    if (a == AW'(22'h000123)) return 16'hBEEF;
    return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction
  assign flash_dq_i  = dq_fn(flash_addr);
  assign flash_ready = (cyc >= rdy_cyc);

  function automatic obs_t observe();
    return {cmd_ready, busy, rsp_valid, rsp_err, flash_ce_n, flash_oe_n, flash_we_n,
            flash_dq_oe, flash_addr, flash_dq_o, rsp_rdata};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic rdy, bsy, rv, err, ce, oe, we, doe,
                      input logic [AW-1:0] a, input logic ca,
                      input logic [DW-1:0] d, input logic [DW-1:0] rd, input logic crd);
    ent_t e;
    e.v = {rdy, bsy, rv, err, ce, oe, we, doe, a, d, rd};
    e.m = {1'b1, 1'b1, 1'b1, rv, 4'hF, {AW{ca}}, {DW{doe}}, {DW{rv & crd}}};
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic ca, input logic [DW-1:0] d);
    for (int p = 0; p < C; p++)
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (p == 0 || p == C - 1), 1'b1, a, ca, d, '0, 1'b0);
  endtask

  // expected trace from the accept cycle through the response cycle
  task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int r, output int lat);
    logic [AW-1:0] sa [6];
    logic [DW-1:0] sd [6];
    int n, k;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    if (op == 2'd0) begin
      for (int p = 0; p < C; p++)
        push(1'b0, 1'b1, 1'b0, 1'b0, p == C - 1, p == C - 1, 1'b1, 1'b0, a, 1'b1, '0, '0, 1'b0);
      push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, dq_fn(a), 1'b1);
      lat = C + 1;
      return;
    end
    sa[0] = AW'(12'h555); sd[0] = 16'h00AA;
    sa[1] = AW'(12'h2AA); sd[1] = 16'h0055;
    sa[2] = AW'(12'h555); sd[2] = (op == 2'd1) ? 16'h00A0 : 16'h0080;
    if (op == 2'd1) begin
      n = 4; sa[3] = a; sd[3] = wd;
    end else begin
      n = 6;
      sa[3] = AW'(12'h555); sd[3] = 16'h00AA;
      sa[4] = AW'(12'h2AA); sd[4] = 16'h0055;
      sa[5] = (op == 2'd2) ? a : AW'(12'h555);
      sd[5] = (op == 2'd2) ? 16'h0030 : 16'h0010;
    end
    for (int i = 0; i < n; i++) push_wr(sa[i], 1'b1, sd[i]);
    rdy_cyc = cyc + 1 + n * C + r;
    k = (r > C) ? r : C;
    if (k <= TMO) begin
      repeat (k + 1) push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      lat = 1 + n * C + k + 1;
    end else begin
      repeat (TMO + 1) push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      push_wr('0, 1'b0, 16'h00F0);
      push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      lat = 1 + n * C + TMO + 1 + C + 1;
    end
  endtask

  task automatic cmp();
    ent_t e;
    obs_t act;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.v = {8'b1000_1110, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}};
      e.m = {8'b1110_1111, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}};
    end
    act = observe();
    total++;
    if (((act ^ e.v) & e.m) != '0) begin
      bad++;
      $display("FAIL cyc=%0d pins act=%h exp=%h mask=%h", cyc, act, e.v, e.m);
    end
    if (rsp_valid) begin rv_cyc = cyc; rv_data = rsp_rdata; rv_err = rsp_err; end
    if (!flash_oe_n) n_oe++;
    if (!flash_we_n) n_we++;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      @(posedge CLK50M); #2;
      n++;
    end
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain timeout left=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int r);
    int lat;
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
    acc_cyc = cyc;
    model_cmd(op, a, wd, r, lat);
    @(posedge CLK50M); #2;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    drain(lat + 4);
  endtask

  initial begin
    int lat, lat2;
    fork
      forever begin
        @(negedge CLK50M);
        if (chk_en) cmp();
      end
    join_none

    repeat (3) @(posedge CLK50M);
    @(negedge CLK50M);
    check("reset_vals", 64'(observe()),
          64'({8'b1000_1110, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}}));
    @(posedge CLK50M); #2;
    RST = 1'b0;
    chk_en = 1'b1;

    // read at 0x123
    n_oe = 0;
    issue(2'd0, AW'(22'h000123), '0, 0);
    check("rd_latency", 64'(rv_cyc - acc_cyc), 64'd5);
    check("rd_data", 64'(rv_data), 64'hBEEF);
    check("rd_err", 64'(rv_err), 64'd0);
    check("rd_oe_window", 64'(n_oe), 64'd3);

    // program, released 50 clocks into WAIT
    n_we = 0;
    issue(2'd1, AW'(22'h000040), 16'h1234, 50);
    check("prog_latency", 64'(rv_cyc - acc_cyc), 64'd68);
    check("prog_we_clocks", 64'(n_we), 64'd8);
    check("prog_err", 64'(rv_err), 64'd0);

    n_we = 0;
    issue(2'd2, AW'(22'h010000), '0, 10);
    check("serase_we_clocks", 64'(n_we), 64'd12);
    issue(2'd3, AW'(22'h3ABCDE), '0, 2);

    // never ready: timeout then F0 write
    n_we = 0;
    issue(2'd1, AW'(22'h000777), 16'h00FF, 1000);
    check("tmo_latency", 64'(rv_cyc - acc_cyc), 64'd85);
    check("tmo_err", 64'(rv_err), 64'd1);
    check("tmo_we_clocks", 64'(n_we), 64'd10);

    // reset during the third unlock write
    cmd_op = 2'd1; cmd_addr = AW'(22'h000040); cmd_wdata = 16'h5678; cmd_valid = 1'b1;
    acc_cyc = cyc;
    model_cmd(2'd1, AW'(22'h000040), 16'h5678, 20, lat);
    @(posedge CLK50M); #2;
    cmd_valid = 1'b0;
    while (cyc < acc_cyc + 2 * C + 2) begin @(posedge CLK50M); #2; end
    RST = 1'b1;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    rdy_cyc = 1 << 30;
    @(posedge CLK50M); #2;
    RST = 1'b0;
    check("rst_mid_strobes", 64'({flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe, cmd_ready, busy}),
          64'(6'b111010));
    check("rst_mid_addr", 64'(flash_addr), 64'd0);
    issue(2'd0, AW'(22'h000200), '0, 0);
    check("rd_after_rst", 64'(rv_data), 64'(dq_fn(AW'(22'h000200))));

    // back-to-back reads with cmd_valid held
    cmd_op = 2'd0; cmd_addr = AW'(22'h001111); cmd_valid = 1'b1;
    acc_cyc = cyc;
    model_cmd(2'd0, AW'(22'h001111), '0, 0, lat);
    model_cmd(2'd0, AW'(22'h002222), '0, 0, lat2);
    @(posedge CLK50M); #2;
    cmd_addr = AW'(22'h002222);
    while (cyc < acc_cyc + lat + 2) begin @(posedge CLK50M); #2; end
    cmd_valid = 1'b0;
    drain(lat2 + 4);
    check("b2b_latency", 64'(rv_cyc - acc_cyc), 64'(2 * lat + 1));
    check("b2b_data", 64'(rv_data), 64'(dq_fn(AW'(22'h002222))));

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), AW'($urandom), DW'($urandom), $urandom_range(0, 75));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK50M); #2; end
    end

    repeat (3) @(posedge CLK50M);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
